// File: rtl/instr_prefetch_queue_pkg.sv
// Shared pipeline definitions for the instruction prefetch queue:
// default geometry, the NOP encoding and a saturating counter helper.
package instr_prefetch_queue_pkg;

   localparam int DEFAULT_DEPTH = 4;
   localparam int DEFAULT_DW    = 32;
   localparam int FLUSH_CNT_W   = 16;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Statistics counters stick at all-ones rather than wrapping back to zero.
   function automatic logic [FLUSH_CNT_W-1:0] sat_inc(input logic [FLUSH_CNT_W-1:0] value);
      return (value == {FLUSH_CNT_W{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/instr_prefetch_queue_ram.sv
// Entry storage for the prefetch queue: one synchronous write port and one
// asynchronous read port. Contents are never cleared; validity lives in the top.
module prefetch_ram #(
   parameter int DEPTH = instr_prefetch_queue_pkg::DEFAULT_DEPTH,
   parameter int WIDTH = 2 * instr_prefetch_queue_pkg::DEFAULT_DW
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode: show-ahead head entry,
// flush on a taken branch, and a saturating count of flushes that discarded work.
module instr_prefetch_queue
   import instr_prefetch_queue_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int DW    = DEFAULT_DW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       if_valid,
   input  logic [DW-1:0]              if_instr,
   input  logic [DW-1:0]              if_npc,
   output logic                       if_ready,
   input  logic                       id_ready,
   output logic [DW-1:0]              IF_ID_instr,
   output logic [DW-1:0]              IF_ID_npc,
   output logic                       id_valid,
   input  logic                       EX_MEM_PCSrc,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [FLUSH_CNT_W-1:0]     flush_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            push;
   logic            pop;
   logic [2*DW-1:0] head_entry;

   assign if_ready = (count != CW'(DEPTH));
   assign id_valid = (count != '0);
   assign push     = if_valid && if_ready;
   assign pop      = id_valid && id_ready;

   // A flushing edge must not write, so a discarded beat never lands in storage.
   prefetch_ram #(
      .DEPTH (DEPTH),
      .WIDTH (2*DW)
   ) u_ram (
      .clk   (clk),
      .we    (push && !EX_MEM_PCSrc && !rst),
      .waddr (wr_ptr),
      .wdata ({if_instr, if_npc}),
      .raddr (rd_ptr),
      .rdata (head_entry)
   );

   // Flush outranks push/pop; pointers wrap naturally at their power-of-two width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         flush_cnt <= '0;
      end else if (EX_MEM_PCSrc) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         if ((count != '0) || if_valid) begin
            flush_cnt <= sat_inc(flush_cnt);
         end
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   assign IF_ID_instr = id_valid ? head_entry[2*DW-1:DW] : DW'(NOP_INSTR);
   assign IF_ID_npc   = id_valid ? head_entry[DW-1:0]    : '0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed, table-driven bench for instr_prefetch_queue plus hand-written
// sequences for asynchronous reset and flush-counter saturation.
module tb_instr_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_npc;
   logic        if_ready;
   logic        id_ready;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_npc;
   logic        id_valid;
   logic        EX_MEM_PCSrc;
   logic [2:0]  count;
   logic [15:0] flush_cnt;

   int checks = 0;
   int passed = 0;

   typedef struct packed {
      logic        iv;
      logic [31:0] instr;
      logic        idr;
      logic        flush;
      logic [2:0]  exp_count;
      logic        exp_valid;
      logic        exp_ready;
      logic [31:0] exp_head;
      logic [15:0] exp_fc;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs [NVEC];

   localparam logic [31:0] IA = 32'h8C01_0004;
   localparam logic [31:0] IB = 32'h8C01_0008;
   localparam logic [31:0] IC = 32'h8C01_000C;
   localparam logic [31:0] ID = 32'h8C01_0010;
   localparam logic [31:0] IE = 32'h8C01_0014;
   localparam logic [31:0] IF = 32'h8C01_0018;

   instr_prefetch_queue #(
      .DEPTH (4),
      .DW    (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_valid     (if_valid),
      .if_instr     (if_instr),
      .if_npc       (if_npc),
      .if_ready     (if_ready),
      .id_ready     (id_ready),
      .IF_ID_instr  (IF_ID_instr),
      .IF_ID_npc    (IF_ID_npc),
      .id_valid     (id_valid),
      .EX_MEM_PCSrc (EX_MEM_PCSrc),
      .count        (count),
      .flush_cnt    (flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic iv, input logic [31:0] instr, input logic idr,
                               input logic flush, input logic [2:0] c, input logic v,
                               input logic r, input logic [31:0] head, input logic [15:0] fc);
      vec_t t;
      t.iv = iv; t.instr = instr; t.idr = idr; t.flush = flush;
      t.exp_count = c; t.exp_valid = v; t.exp_ready = r; t.exp_head = head; t.exp_fc = fc;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drive one cycle's inputs, then sample just after the rising edge.
   task automatic applyStimulus(input logic iv, input logic [31:0] instr, input logic idr, input logic flush);
      if_valid     = iv;
      if_instr     = instr;
      if_npc       = instr + 32'd4;
      id_ready     = idr;
      EX_MEM_PCSrc = flush;
      @(posedge clk);
      #1;
   endtask

   task automatic checkAll(input string tag, input vec_t v);
      checkOutput({tag, " count"},    32'(count),     32'(v.exp_count));
      checkOutput({tag, " id_valid"}, 32'(id_valid),  32'(v.exp_valid));
      checkOutput({tag, " if_ready"}, 32'(if_ready),  32'(v.exp_ready));
      checkOutput({tag, " instr"},    IF_ID_instr,    v.exp_valid ? v.exp_head : 32'h0);
      checkOutput({tag, " npc"},      IF_ID_npc,      v.exp_valid ? v.exp_head + 32'd4 : 32'h0);
      checkOutput({tag, " flush_cnt"}, 32'(flush_cnt), 32'(v.exp_fc));
   endtask

   initial begin
      //            iv  instr idr fl  cnt v  r  head fc
      vecs[0]  = mk(1, IA, 0, 0, 3'd1, 1, 1, IA, 16'd0);
      vecs[1]  = mk(1, IB, 0, 0, 3'd2, 1, 1, IA, 16'd0);
      vecs[2]  = mk(1, IC, 0, 0, 3'd3, 1, 1, IA, 16'd0);
      vecs[3]  = mk(1, ID, 0, 0, 3'd4, 1, 0, IA, 16'd0);
      vecs[4]  = mk(1, IE, 0, 0, 3'd4, 1, 0, IA, 16'd0);
      vecs[5]  = mk(1, IE, 1, 0, 3'd3, 1, 1, IB, 16'd0);
      vecs[6]  = mk(1, IE, 0, 0, 3'd4, 1, 0, IB, 16'd0);
      vecs[7]  = mk(0, 32'h0, 1, 0, 3'd3, 1, 1, IC, 16'd0);
      vecs[8]  = mk(0, 32'h0, 1, 0, 3'd2, 1, 1, ID, 16'd0);
      vecs[9]  = mk(0, 32'h0, 1, 0, 3'd1, 1, 1, IE, 16'd0);
      vecs[10] = mk(0, 32'h0, 1, 0, 3'd0, 0, 1, 32'h0, 16'd0);
      vecs[11] = mk(0, 32'h0, 1, 0, 3'd0, 0, 1, 32'h0, 16'd0);
      vecs[12] = mk(1, IA, 1, 0, 3'd1, 1, 1, IA, 16'd0);
      vecs[13] = mk(1, IB, 1, 0, 3'd1, 1, 1, IB, 16'd0);
      vecs[14] = mk(1, IC, 1, 0, 3'd1, 1, 1, IC, 16'd0);
      vecs[15] = mk(1, ID, 1, 0, 3'd1, 1, 1, ID, 16'd0);
      vecs[16] = mk(1, IE, 1, 0, 3'd1, 1, 1, IE, 16'd0);
      vecs[17] = mk(1, IF, 1, 0, 3'd1, 1, 1, IF, 16'd0);
      vecs[18] = mk(1, IA, 0, 0, 3'd2, 1, 1, IF, 16'd0);
      vecs[19] = mk(1, IB, 0, 0, 3'd3, 1, 1, IF, 16'd0);
      vecs[20] = mk(1, IC, 0, 1, 3'd0, 0, 1, 32'h0, 16'd1);
      vecs[21] = mk(0, 32'h0, 0, 1, 3'd0, 0, 1, 32'h0, 16'd1);
      vecs[22] = mk(1, IA, 0, 1, 3'd0, 0, 1, 32'h0, 16'd2);
      vecs[23] = mk(1, ID, 0, 0, 3'd1, 1, 1, ID, 16'd2);
      vecs[24] = mk(1, IE, 1, 0, 3'd1, 1, 1, IE, 16'd2);

      rst          = 1'b1;
      if_valid     = 1'b0;
      if_instr     = 32'h0;
      if_npc       = 32'h0;
      id_ready     = 1'b0;
      EX_MEM_PCSrc = 1'b0;
      @(posedge clk);
      #1;
      checkAll("reset", mk(0, 32'h0, 0, 0, 3'd0, 0, 1, 32'h0, 16'd0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].iv, vecs[i].instr, vecs[i].idr, vecs[i].flush);
         checkAll($sformatf("vec%0d", i), vecs[i]);
      end

      // Reach two entries, then assert reset between edges.
      applyStimulus(1, IF, 0, 0);
      checkOutput("pre-reset count", 32'(count), 32'd2);
      @(negedge clk);
      if_valid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("async rst count", 32'(count), 32'd0);
      checkOutput("async rst id_valid", 32'(id_valid), 32'd0);
      checkOutput("async rst if_ready", 32'(if_ready), 32'd1);
      checkOutput("async rst instr", IF_ID_instr, 32'h0);
      checkOutput("async rst flush_cnt", 32'(flush_cnt), 32'd0);
      #1;
      rst = 1'b0;
      applyStimulus(1, IA, 0, 0);
      checkAll("post-reset push", mk(1, IA, 0, 0, 3'd1, 1, 1, IA, 16'd0));

      // Saturation: 65534 counted flushes first, then cross and sit on the ceiling.
      if_valid     = 1'b1;
      if_instr     = IB;
      if_npc       = IB + 32'd4;
      EX_MEM_PCSrc = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      checkOutput("sat flush_cnt 65534", 32'(flush_cnt), 32'h0000_FFFE);
      applyStimulus(1, IB, 0, 1);
      checkOutput("sat flush_cnt 65535", 32'(flush_cnt), 32'h0000_FFFF);
      applyStimulus(1, IC, 0, 1);
      checkOutput("sat flush_cnt held", 32'(flush_cnt), 32'h0000_FFFF);
      checkOutput("sat count", 32'(count), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 Parameter DW, default 32, instruction and NPC width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with the clock and reset ports named as the codebase does.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 if_valid  input  1  fetch stage presents an instruction.
REQ-007 if_instr  input  DW  fetched instruction.
REQ-008 if_npc  input  DW  PC+4 of fetched instruction.
REQ-009 if_ready  output  1  queue accepts the fetch beat this cycle.
REQ-010 id_ready  input  1  decode consumes the head entry (low = decode stall).
REQ-011 IF_ID_instr  output  DW  head instruction to decode.
REQ-012 IF_ID_npc  output  DW  head NPC to decode.
REQ-013 id_valid  output  1  head entry is valid.
REQ-014 EX_MEM_PCSrc  input  1  taken branch; flush all entries.
REQ-015 count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-016 flush_cnt  output  16  number of flushes that discarded at least one entry; saturates.

Function
REQ-017 Push on if_valid && if_ready; pop on id_valid && id_ready; both evaluated at the same rising edge.
REQ-018 if_ready SHALL equal (count != DEPTH); combinational from registered count only.
REQ-019 id_valid SHALL equal (count != 0).
REQ-020 IF_ID_instr/IF_ID_npc SHALL show the head entry combinationally (show-ahead); while id_valid=0 they SHALL be 32'h0000_0000 (NOP) and 0.
REQ-021 Latency: an entry pushed into an empty queue at edge N SHALL appear with id_valid=1 after edge N; no same-cycle bypass.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH: count unchanged; both pointers advance.
REQ-023 Full queue: no push (if_ready=0); a pop still occurs, and if_ready rises after that edge.
REQ-024 Empty queue: no pop; a push still occurs.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count is kept as a separate register, not derived from the pointers.
REQ-026 EX_MEM_PCSrc=1 at an edge SHALL have priority: set pointers and count to 0, discard any simultaneous push and pop, and present NOP on the next cycle.
REQ-027 flush_cnt SHALL increment by 1 on a flush edge where count != 0 or a push was offered; it holds at 16'hFFFF.
REQ-028 Storage contents are not cleared on a flush or reset; only the valid state is cleared.

Reset
REQ-029 While rst=1: pointers=0, count=0, flush_cnt=0, id_valid=0, if_ready=1, and IF_ID outputs=NOP/0.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-031 The first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-032 NOP_INSTR (32'h0000_0000) and default DEPTH/DW SHALL reside in the shared pipeline package.
REQ-033 Entry storage SHALL be one sub-module, prefetch_ram: DEPTH x (2*DW), one synchronous write port and one asynchronous read port.
REQ-034 The pointer, count and flush logic SHALL reside in instr_prefetch_queue.

Verification
REQ-035 Fill: push instr 0x8C010004..0x8C01000C (3 beats) with id_ready=0 -> count=3, head=0x8C010004, if_ready=1.
REQ-036 Full: push 5 beats with id_ready=0 -> count=4, if_ready=0, fifth beat held until one pop, then accepted.
REQ-037 Stream: if_valid=1 and id_ready=1 continuously -> after 1-cycle fill, one instruction per cycle in order, count stays 1, pointers wrap past 3.
REQ-038 Flush: count=3 with EX_MEM_PCSrc=1 and a simultaneous push -> next cycle count=0, id_valid=0, IF_ID_instr=0, flush_cnt=1.
REQ-039 Async reset: assert rst between edges with count=2 -> id_valid=0 and count=0 before the next edge.
REQ-040 Saturation: force 65536 non-empty flushes -> flush_cnt=16'hFFFF, unchanged after another flush.
